// File: rtl/dsp_pkg.sv
// Shared DSP helpers: fixed-point fraction bits of a coefficient and the matching
// round-half-up constant. Coefficients carry 3 integer bits, giving a [-4, 4) range.
package dsp_pkg;

    function automatic int coef_frac_bits(input int coef_width);
        return coef_width - 3;
    endfunction

    function automatic int round_const(input int coef_width);
        return 1 << (coef_frac_bits(coef_width) - 1);
    endfunction

endpackage

// File: rtl/biquad_round_sat.sv
// Accumulator-to-sample conversion: add half an LSB, arithmetic shift right by the
// coefficient fraction bits, then clamp to the signed sample range.
module biquad_round_sat
    import dsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COEF_WIDTH   = 16,
    parameter int ACC_WIDTH    = 27
) (
    input  logic signed [ACC_WIDTH-1:0]    acc_i,
    output logic signed [SAMPLE_WIDTH-1:0] y_o
);

    localparam int F = coef_frac_bits(COEF_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(round_const(COEF_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (SAMPLE_WIDTH - 1)));

    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;

    // The accumulator has guard bits to spare, so adding the rounding constant cannot overflow.
    always_comb begin
        sum     = acc_i + RND;
        shifted = sum >>> F;
        if (shifted > SAT_MAX) begin
            y_o = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            y_o = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            y_o = shifted[SAMPLE_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fast_biquad_filter.sv
// Full-rate Direct Form I biquad: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, one sample per clk,
// output registered on the same edge that accepts the input.
module fast_biquad_filter
    import dsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COEF_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [COEF_WIDTH-1:0]   b0,
    input  logic signed [COEF_WIDTH-1:0]   b1,
    input  logic signed [COEF_WIDTH-1:0]   b2,
    input  logic signed [COEF_WIDTH-1:0]   a1,
    input  logic signed [COEF_WIDTH-1:0]   a2,
    input  logic signed [SAMPLE_WIDTH-1:0] in,
    input  logic                           in_valid,
    output logic signed [SAMPLE_WIDTH-1:0] out,
    output logic                           out_valid
);

    localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 3;

    logic signed [SAMPLE_WIDTH-1:0] x1_q, x2_q, y2_q, out_q;
    logic                           out_valid_q;
    logic signed [PROD_W-1:0]       p_b0, p_b1, p_b2, p_a1, p_a2;
    logic signed [ACC_W-1:0]        acc_d;
    logic signed [SAMPLE_WIDTH-1:0] y_d;

    // out_q doubles as y[n-1]: the feedback uses exactly the saturated value driven on out.
    always_comb begin
        p_b0  = PROD_W'(b0) * PROD_W'(in);
        p_b1  = PROD_W'(b1) * PROD_W'(x1_q);
        p_b2  = PROD_W'(b2) * PROD_W'(x2_q);
        p_a1  = PROD_W'(a1) * PROD_W'(out_q);
        p_a2  = PROD_W'(a2) * PROD_W'(y2_q);
        acc_d = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2) - ACC_W'(p_a1) - ACC_W'(p_a2);
    end

    biquad_round_sat #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .COEF_WIDTH   (COEF_WIDTH),
        .ACC_WIDTH    (ACC_W)
    ) u_round_sat (
        .acc_i (acc_d),
        .y_o   (y_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (in_valid) begin
            x1_q        <= in;
            x2_q        <= x1_q;
            y2_q        <= out_q;
            out_q       <= y_d;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fast_biquad_filter.sv
// Self-checking bench for fast_biquad_filter against an integer-arithmetic reference of the
// difference equation with round-half-up, floor shift and clamp.
module tb_fast_biquad_filter;

    localparam int SW  = 8;
    localparam int CW  = 16;
    localparam int F   = CW - 3;
    localparam longint RND = longint'(1) << (F - 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [CW-1:0] b0, b1, b2, a1, a2;
    logic signed [SW-1:0] in;
    logic                 in_valid;
    logic signed [SW-1:0] out;
    logic                 out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state
    longint mx1, mx2, my1, my2;
    longint exp_out;
    bit     exp_valid;

    always #5 clk = ~clk;

    fast_biquad_filter #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .a1        (a1),
        .a2        (a2),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    task automatic set_coefs(input int cb0, input int cb1, input int cb2, input int ca1, input int ca2);
        b0 = CW'(cb0);
        b1 = CW'(cb1);
        b2 = CW'(cb2);
        a1 = CW'(ca1);
        a2 = CW'(ca2);
    endtask

    // Drive one cycle and advance the reference model; outputs are sampled 1 time unit after the edge.
    task automatic drive(input int x, input bit v, input bit r);
        longint acc, y;
        @(negedge clk);
        in       = SW'(x);
        in_valid = v;
        reset    = r;
        @(posedge clk);
        #1;
        if (r) begin
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
            exp_out   = 0;
            exp_valid = 1'b0;
        end else if (v) begin
            acc = longint'(b0) * x + longint'(b1) * mx1 + longint'(b2) * mx2
                - longint'(a1) * my1 - longint'(a2) * my2;
            y = (acc + RND) >>> F;
            if (y > 127)  y = 127;
            if (y < -128) y = -128;
            mx2 = mx1; mx1 = x;
            my2 = my1; my1 = y;
            exp_out   = y;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        set_coefs(8192, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(63, 1'b1, 1'b1);
            total++;
            if (out !== 8'sd0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d out=%0d valid=%b expected out=0 valid=0", i, out, out_valid);
            end
        end
        drive(63, 1'b1, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out !== 8'sd63) begin
            bad++;
            $display("FAIL reset_release out=%0d valid=%b expected out=63 valid=1", out, out_valid);
        end
    endtask

    task automatic test_identity();
        int exp_b0 [6] = '{64, 0, 0, 0, 0, 0};
        int exp_b1 [6] = '{0, 64, 0, 0, 0, 0};
        set_coefs(8192, 0, 0, 0, 0);
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(i == 0 ? 64 : 0, 1'b1, 1'b0);
            total++;
            if (longint'(out) !== longint'(exp_b0[i]) || longint'(out) !== exp_out || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL identity_b0 n=%0d out=%0d valid=%b expected %0d", i, out, out_valid, exp_b0[i]);
            end
        end
        set_coefs(0, 8192, 0, 0, 0);
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(i == 0 ? 64 : 0, 1'b1, 1'b0);
            total++;
            if (longint'(out) !== longint'(exp_b1[i]) || longint'(out) !== exp_out) begin
                bad++;
                $display("FAIL identity_b1 n=%0d out=%0d expected %0d", i, out, exp_b1[i]);
            end
        end
    endtask

    task automatic test_default_step();
        int first [5] = '{0, 16, 24, 12, 14};
        set_coefs(0, 2048, 2048, 4096, 4096);
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            drive(63, 1'b1, 1'b0);
            total++;
            if (longint'(out) !== exp_out || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL step_model n=%0d out=%0d valid=%b expected %0d", i, out, out_valid, exp_out);
            end
            if (i < 5) begin
                total++;
                if (longint'(out) !== longint'(first[i])) begin
                    bad++;
                    $display("FAIL step_const n=%0d out=%0d expected %0d", i, out, first[i]);
                end
            end
        end
        total++;
        if (out !== 8'sd16) begin
            bad++;
            $display("FAIL step_settle out=%0d expected 16", out);
        end
    endtask

    task automatic test_saturation();
        set_coefs(16384, 0, 0, 0, 0);
        drive(0, 1'b0, 1'b1);
        drive(100, 1'b1, 1'b0);
        total++;
        if (out !== 8'sd127) begin
            bad++;
            $display("FAIL sat_pos out=%0d expected 127", out);
        end
        drive(-100, 1'b1, 1'b0);
        total++;
        if (out !== -8'sd128) begin
            bad++;
            $display("FAIL sat_neg out=%0d expected -128", out);
        end
        set_coefs(8192, 0, 0, -16383, 0);
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive(63, 1'b1, 1'b0);
            total++;
            if (longint'(out) !== exp_out) begin
                bad++;
                $display("FAIL unstable n=%0d out=%0d expected %0d", i, out, exp_out);
            end
        end
        total++;
        if (out !== 8'sd127) begin
            bad++;
            $display("FAIL unstable_rail out=%0d expected 127", out);
        end
    endtask

    task automatic test_gaps();
        longint held;
        set_coefs(0, 2048, 2048, 4096, 4096);
        drive(0, 1'b0, 1'b1);
        held = 0;
        for (int i = 0; i < 24; i++) begin
            drive(63, (i % 2) == 0, 1'b0);
            total++;
            if ((i % 2) == 0) begin
                if (longint'(out) !== exp_out || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL gaps_accept i=%0d out=%0d valid=%b expected %0d", i, out, out_valid, exp_out);
                end
                held = exp_out;
            end else if (longint'(out) !== held || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL gaps_hold i=%0d out=%0d valid=%b expected %0d valid=0", i, out, out_valid, held);
            end
        end
    endtask

    task automatic test_square();
        int x;
        set_coefs(0, 2048, 2048, 4096, 4096);
        drive(0, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            x = ((n * 107) % 10000) < 5000 ? 63 : -64;
            drive(x, 1'b1, 1'b0);
            total++;
            if (longint'(out) !== exp_out) begin
                bad++;
                $display("FAIL square n=%0d out=%0d expected %0d", n, out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        int  x;
        bit  v, r;
        set_coefs(0, 2048, 2048, 4096, 4096);
        drive(0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                set_coefs(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 65535)));
            end
            x = int'($urandom_range(0, 255)) - 128;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 99) == 0;
            drive(x, v, r);
            total++;
            if (longint'(out) !== exp_out || out_valid !== exp_valid) begin
                bad++;
                $display("FAIL random n=%0d out=%0d valid=%b expected %0d valid=%b", n, out, out_valid, exp_out, exp_valid);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in       = '0;
        in_valid = 1'b0;
        set_coefs(0, 0, 0, 0, 0);
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        exp_out   = 0;
        exp_valid = 1'b0;
        test_reset();
        test_identity();
        test_default_step();
        test_saturation();
        test_gaps();
        test_square();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
